// File: rtl/graycode_conv_sched.sv
// rtl/graycode_conv_sched.sv - round-robin scheduled shared Gray/binary converter
// Optional GRAYCODE_SERIAL_EN selects a bit-serial engine (DATA_W cycles) instead of the 1-cycle XOR chain.
module graycode_conv_sched #(
    parameter int  DATA_W  = 4,
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_dir,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     grant_idx;
    logic                found;
    logic [DATA_W-1:0]   cap_data;
    logic                cap_dir;

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_w;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_grant) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found     = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE && found) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

`ifdef GRAYCODE_SERIAL_EN
    localparam int IDX_W = $clog2(DATA_W);

    logic [IDX_W-1:0]  bit_idx;
    logic              prev_bit;
    logic [DATA_W-1:0] cap_shr;
    logic              ser_bit;

    // prev_bit holds the previously produced binary bit; it is 0 above the MSB.
    assign cap_shr = cap_data >> 1;
    assign ser_bit = cap_data[bit_idx] ^ (cap_dir ? prev_bit : cap_shr[bit_idx]);
`else
    function automatic logic [DATA_W-1:0] convert(input logic dir, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        r[DATA_W-1] = d[DATA_W-1];
        for (int k = DATA_W - 2; k >= 0; k--) begin
            r[k] = dir ? (r[k+1] ^ d[k]) : (d[k+1] ^ d[k]);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_data   <= '0;
            rsp_id     <= '0;
            cap_data   <= '0;
            cap_dir    <= 1'b0;
`ifdef GRAYCODE_SERIAL_EN
            bit_idx    <= '0;
            prev_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cap_data   <= req_data[grant_idx*DATA_W +: DATA_W];
                        cap_dir    <= req_dir[grant_idx];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= CONV;
`ifdef GRAYCODE_SERIAL_EN
                        bit_idx    <= IDX_W'(DATA_W - 1);
                        prev_bit   <= 1'b0;
`endif
                    end
                end
                CONV: begin
`ifdef GRAYCODE_SERIAL_EN
                    rsp_data[bit_idx] <= ser_bit;
                    prev_bit          <= ser_bit;
                    if (bit_idx == '0) begin
                        state <= DONE;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
`else
                    rsp_data <= convert(cap_dir, cap_data);
                    state    <= DONE;
`endif
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
